// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//
// Multi-cycle 32-bit unsigned multiply (MULU) and unsigned divide (DIVU)
// sequencer. It computes one iteration per clock by steering an external
// combinational alu. Only two alu operations are used:
//   - ADDU, with the carry-out taken from alu_flags[0]
//   - NOT
//
// MULU is a shift-add multiplier (32 iterations). DIVU negates the divisor in
// two cycles (NOT, then +1) and then runs a restoring division (32 iterations).
//
// Handshake: the execute stage raises start for one cycle and samples op,
// src_a and src_b with it. A start is accepted only while busy is low (IDLE).
// Any start seen while busy is dropped, and the operands are not resampled.
// When the result is ready, done pulses high for exactly one cycle, and busy
// stays high during that cycle. res_lo, res_hi and div_zero keep the last
// result until the next accepted start.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start, op     request (op: 0 = MULU, 1 = DIVU)
//   src_a, src_b  multiplicand/dividend, multiplier/divisor
//   busy, done    status; done is a one-cycle pulse
//   div_zero      set by a DIVU whose divisor is zero
//   res_lo        product[31:0] / quotient
//   res_hi        product[63:32] / remainder
//   alu_opcode    drive to the alu opcode input
//   alu_a, alu_b  drive to the alu operand inputs
//   alu_out       alu result
//   alu_flags     alu flags; only bit 0 (ADDU carry-out) is used
//   dbg_state     current FSM state, exported for checkers
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
   parameter int         WIDTH       = 32,
   parameter int         CNT_W       = 5,
   parameter logic [5:0] OPCODE_ADDU = 6'h21,
   parameter logic [5:0] OPCODE_NOT  = 6'h27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [5:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [2:0]       alu_flags,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_NEG1 = 3'd1,
      S_NEG2 = 3'd2,
      S_MUL  = 3'd3,
      S_DIV  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_next;

   // The two result registers are shared by both operations:
   //   MULU: reg_hi = hi,  reg_lo = lo (the multiplier shifts out of lo)
   //   DIVU: reg_hi = rem, reg_lo = quo (the dividend shifts out of quo)
   // Because of this, the result outputs are plain views of these registers.
   logic [WIDTH-1:0] reg_hi;
   logic [WIDTH-1:0] reg_lo;

   // opnd holds the multiplicand for MULU. For DIVU it holds the divisor,
   // which NEG1/NEG2 then turn into the negated divisor.
   logic [WIDTH-1:0] opnd;
   logic [CNT_W-1:0] cnt;
   logic             dz;

   // Division step: shift the next dividend bit into the remainder. The
   // subtraction fits only if the shifted-out bit s[WIDTH] is set, or if
   // s[WIDTH-1:0] + (-d) carries out.
   logic [WIDTH:0]   s;
   logic             ge;
   logic             carry;
   logic             flags_unused;

   assign carry        = alu_flags[0];
   assign flags_unused = ^alu_flags[2:1];
   assign s            = {reg_hi, reg_lo[WIDTH-1]};
   assign ge           = s[WIDTH] | carry;

   // Next state and alu drive
   always_comb begin
      state_next = state;
      alu_opcode = OPCODE_ADDU;
      alu_a      = '0;
      alu_b      = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (!op)
                  state_next = S_MUL;
               else if (src_b == '0)
                  state_next = S_DONE;
               else
                  state_next = S_NEG1;
            end
         end
         S_NEG1: begin
            alu_opcode = OPCODE_NOT;
            alu_a      = opnd;
            state_next = S_NEG2;
         end
         S_NEG2: begin
            alu_opcode = OPCODE_ADDU;
            alu_a      = opnd;
            alu_b      = ONE;
            state_next = S_DIV;
         end
         S_MUL: begin
            alu_opcode = OPCODE_ADDU;
            alu_a      = reg_hi;
            alu_b      = opnd;
            if (cnt == CNT_LAST)
               state_next = S_DONE;
         end
         S_DIV: begin
            alu_opcode = OPCODE_ADDU;
            alu_a      = s[WIDTH-1:0];
            alu_b      = opnd;
            if (cnt == CNT_LAST)
               state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         reg_hi <= '0;
         reg_lo <= '0;
         opnd   <= '0;
         cnt    <= '0;
         dz     <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt <= '0;
                  dz  <= op & (src_b == '0);
                  if (!op) begin
                     reg_hi <= '0;
                     reg_lo <= src_b;
                     opnd   <= src_a;
                  end else if (src_b == '0) begin
                     // Divide by zero: the result is final right away.
                     reg_hi <= src_a;
                     reg_lo <= '1;
                     opnd   <= '0;
                  end else begin
                     reg_hi <= '0;
                     reg_lo <= src_a;
                     opnd   <= src_b;
                  end
               end
            end
            S_NEG1, S_NEG2: begin
               opnd <= alu_out;
            end
            S_MUL: begin
               // Shift the 65-bit {carry, hi, lo} right by one. The sum
               // replaces hi only when the current multiplier bit is set.
               if (reg_lo[0]) begin
                  reg_hi <= {carry, alu_out[WIDTH-1:1]};
                  reg_lo <= {alu_out[0], reg_lo[WIDTH-1:1]};
               end else begin
                  reg_hi <= {1'b0, reg_hi[WIDTH-1:1]};
                  reg_lo <= {reg_hi[0], reg_lo[WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
            end
            S_DIV: begin
               reg_hi <= ge ? alu_out : s[WIDTH-1:0];
               reg_lo <= {reg_lo[WIDTH-2:0], ge};
               cnt    <= cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign div_zero  = dz;
   assign res_lo    = reg_lo;
   assign res_hi    = reg_hi;
   assign dbg_state = state;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Directed test of alu_muldiv_seq. A behavioural model of the alu (ADDU with
// carry, NOT) is attached to the sequencer. The unused alu flags are tied
// high, so any read of them shows up as a wrong result.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_seq;

   localparam logic [5:0] OP_ADDU = 6'h21;
   localparam logic [5:0] OP_NOT  = 6'h27;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam int         LIMIT   = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] res_lo;
   logic [31:0] res_hi;
   logic [5:0]  alu_opcode;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_out;
   logic [2:0]  alu_flags;
   logic [2:0]  dbg_state;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   alu_muldiv_seq #(
      .WIDTH(32), .CNT_W(5), .OPCODE_ADDU(OP_ADDU), .OPCODE_NOT(OP_NOT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .div_zero(div_zero),
      .res_lo(res_lo), .res_hi(res_hi),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- alu model ----------------
   logic [32:0] alu_sum;
   assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_out   = (alu_opcode == OP_ADDU) ? alu_sum[31:0] :
                      (alu_opcode == OP_NOT)  ? ~alu_a : 32'hDEAD_BEEF;
   assign alu_flags = {2'b11, (alu_opcode == OP_ADDU) ? alu_sum[32] : 1'b0};

   // Advance one clock and sample 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Driver: issue one operation in the current cycle T and follow it to done.
   // lat is the cycle offset from T at which done was seen (-1 on timeout).
   // busy1/dz1 are sampled at T+1. idle_after is 1 if the cycle after done
   // shows done=0 and busy=0.
   task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] lo, output logic [31:0] hi,
                        output logic dz, output logic busy1, output logic dz1,
                        output logic idle_after);
      int n;
      start = 1'b1; op = o; src_a = a; src_b = b;
      cyc();
      start = 1'b0;
      src_a = $urandom; src_b = $urandom; op = ~o;
      busy1 = busy; dz1 = div_zero;
      n = 1;
      while (done !== 1'b1 && n < LIMIT) begin
         cyc();
         n++;
      end
      lat = (done === 1'b1) ? n : -1;
      lo = res_lo; hi = res_hi; dz = div_zero;
      cyc();
      idle_after = (done === 1'b0) && (busy === 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 ||
          res_lo !== 32'h0 || res_hi !== 32'h0 || dbg_state !== ST_IDLE) begin
         fails++;
         $display("FAIL reset: busy=%b done=%b dz=%b lo=%h hi=%h st=%0d required 0/0/0/0/0/%0d",
                  busy, done, div_zero, res_lo, res_hi, dbg_state, ST_IDLE);
      end else passed++;
      checks++;
      if (alu_opcode !== OP_ADDU || alu_a !== 32'h0 || alu_b !== 32'h0) begin
         fails++;
         $display("FAIL idle_alu_drive: op=%h a=%h b=%h required %h/0/0",
                  alu_opcode, alu_a, alu_b, OP_ADDU);
      end else passed++;
   endtask

   task automatic run_and_check(input string name, input logic o,
                                input logic [31:0] a, input logic [31:0] b,
                                input int exp_lat, input logic [31:0] exp_lo,
                                input logic [31:0] exp_hi, input logic exp_dz);
      int lat; logic [31:0] lo, hi; logic dz, b1, dz1, idle;
      do_op(o, a, b, lat, lo, hi, dz, b1, dz1, idle);
      checks++;
      if (lat != exp_lat || b1 !== 1'b1) begin
         fails++;
         $display("FAIL %s_latency: done at T+%0d busy@T+1=%b required T+%0d busy=1",
                  name, lat, b1, exp_lat);
      end else passed++;
      checks++;
      if (lo !== exp_lo || hi !== exp_hi || dz !== exp_dz) begin
         fails++;
         $display("FAIL %s_result: lo=%h hi=%h dz=%b required lo=%h hi=%h dz=%b",
                  name, lo, hi, dz, exp_lo, exp_hi, exp_dz);
      end else passed++;
      checks++;
      if (idle !== 1'b1) begin
         fails++;
         $display("FAIL %s_pulse: cycle after done not idle (got 0) required 1", name);
      end else passed++;
   endtask

   task automatic test_mulu();
      run_and_check("mulu_3x5", 1'b0, 32'd3, 32'd5, 33, 32'd15, 32'd0, 1'b0);
      run_and_check("mulu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
                    32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
      run_and_check("mulu_shift", 1'b0, 32'h1234_5678, 32'h0000_0100, 33,
                    32'h3456_7800, 32'h0000_0012, 1'b0);
      run_and_check("mulu_zero", 1'b0, 32'h0, 32'hABCD_0123, 33, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic test_divu();
      run_and_check("divu_100_7", 1'b1, 32'd100, 32'd7, 35, 32'd14, 32'd2, 1'b0);
      run_and_check("divu_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 35,
                    32'hFFFF_FFFF, 32'h0, 1'b0);
      run_and_check("divu_small", 1'b1, 32'd7, 32'd100, 35, 32'd0, 32'd7, 1'b0);
      run_and_check("divu_msb_3", 1'b1, 32'h8000_0000, 32'd3, 35,
                    32'h2AAA_AAAA, 32'd2, 1'b0);
      run_and_check("divu_big", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 35,
                    32'd1, 32'h7FFF_FFFE, 1'b0);
   endtask

   task automatic test_div_zero();
      int lat; logic [31:0] lo, hi; logic dz, b1, dz1, idle;
      run_and_check("divu_zero", 1'b1, 32'h1234_5678, 32'h0, 1,
                    32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      // The flag must hold in IDLE and clear once the next start is accepted.
      checks++;
      if (div_zero !== 1'b1) begin
         fails++;
         $display("FAIL div_zero_hold: got %b required 1", div_zero);
      end else passed++;
      do_op(1'b0, 32'd6, 32'd7, lat, lo, hi, dz, b1, dz1, idle);
      checks++;
      if (dz1 !== 1'b0 || lat != 33 || lo !== 32'd42 || hi !== 32'd0) begin
         fails++;
         $display("FAIL div_zero_clear: dz@T+1=%b lat=%0d lo=%h hi=%h required 0/33/2a/0",
                  dz1, lat, lo, hi);
      end else passed++;
   endtask

   task automatic test_ignored_start();
      int n;
      start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd5;
      cyc();
      start = 1'b0;
      n = 1;
      while (n < 5) begin cyc(); n++; end
      start = 1'b1; op = 1'b1; src_a = 32'd1000; src_b = 32'd3;
      cyc(); n++;
      start = 1'b0;
      while (done !== 1'b1 && n < LIMIT) begin cyc(); n++; end
      checks++;
      if (done !== 1'b1 || n != 33 || res_lo !== 32'd15 || res_hi !== 32'd0) begin
         fails++;
         $display("FAIL ignored_start: done=%b at T+%0d lo=%h hi=%h required 1 at T+33 lo=f hi=0",
                  done, n, res_lo, res_hi);
      end else passed++;
      cyc();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL ignored_start_idle: busy=%b done=%b required 0/0", busy, done);
      end else passed++;
   endtask

   task automatic test_reset_mid_op();
      int n;
      logic early_done;
      early_done = 1'b0;
      start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7;
      cyc();
      start = 1'b0;
      n = 1;
      while (n < 10) begin
         if (done === 1'b1) early_done = 1'b1;
         cyc(); n++;
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (early_done || busy !== 1'b0 || done !== 1'b0 || res_lo !== 32'h0 ||
          res_hi !== 32'h0 || dbg_state !== ST_IDLE || div_zero !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_op: early=%b busy=%b done=%b lo=%h hi=%h st=%0d dz=%b required 0/0/0/0/0/%0d/0",
                  early_done, busy, done, res_lo, res_hi, dbg_state, div_zero, ST_IDLE);
      end else passed++;
      cyc();
      cyc();
      run_and_check("divu_after_rst", 1'b1, 32'd100, 32'd7, 35, 32'd14, 32'd2, 1'b0);
   endtask

   task automatic test_back_to_back();
      // Each do_op returns in IDLE, so these starts arrive on consecutive
      // acceptable cycles.
      run_and_check("b2b_div", 1'b1, 32'd1000, 32'd10, 35, 32'd100, 32'd0, 1'b0);
      run_and_check("b2b_mul", 1'b0, 32'h0001_0000, 32'h0001_0000, 33,
                    32'h0, 32'h0000_0001, 1'b0);
      run_and_check("b2b_dz",  1'b1, 32'hCAFE_F00D, 32'h0, 1,
                    32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b1);
   endtask

   initial begin
      test_reset();
      test_mulu();
      test_divu();
      test_div_zero();
      test_ignored_start();
      test_reset_mid_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that performs 32-bit unsigned multiply (MULU) and unsigned divide (DIVU) by driving the existing combinational alu through one iteration per clock. It uses only the alu's ADDU and NOT operations. It owns the alu's opcode/in_a/in_b inputs while busy, and sits beside the execute stage, which issues a start and waits for done.

Parameters:
WIDTH, 32, operand width; fixed at 32 to match the alu.
CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only in IDLE
op  input  1  0 = MULU, 1 = DIVU; sampled with start
src_a  input  32  multiplicand / dividend; sampled with start
src_b  input  32  multiplier / divisor; sampled with start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; results valid
div_zero  output  1  set at done of a DIVU with src_b==0; cleared on next accepted start
res_lo  output  32  product[31:0] / quotient
res_hi  output  32  product[63:32] / remainder
alu_opcode  output  6  to alu opcode (`OPCODE_* from instr_syntax.v)
alu_a  output  32  to alu in_a
alu_b  output  32  to alu in_b
alu_out  input  32  from alu out
alu_flags  input  3  from alu flags; [0] = unsigned carry-out of ADDU

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high.
- Reset: state IDLE. busy=0, done=0, div_zero=0, res_lo=res_hi=0, counter=0, all internal registers 0. Reset mid-operation aborts the operation with no done pulse.
- alu drive is combinational from state/registers.
  - IDLE and DONE: alu_opcode=`OPCODE_ADDU, alu_a=alu_b=0.
- States: IDLE, NEG1, NEG2, MUL, DIV, DONE.
- IDLE, start=1 (cycle T):
  - Latch operands, clear div_zero, counter=0.
  - op=0 -> MUL. op=1 with src_b!=0 -> NEG1. op=1 with src_b==0 -> DONE.
- start while busy is ignored; operands are not resampled.
- MUL (shift-add, 32 cycles, T+1..T+32). Registers: hi, lo (lo preloaded with src_b, hi=0), mcand=src_a.
  - Drive alu ADDU, alu_a=hi, alu_b=mcand.
  - If lo[0]: {hi,lo} <= {alu_flags[0], alu_out, lo[31:1]}.
  - Else: {hi,lo} <= {1'b0, hi, lo[31:1]}.
  - counter++. When counter==31, go to DONE.
- NEG1 (T+1): alu NOT, alu_a=divisor; nd <= alu_out.
- NEG2 (T+2): alu ADDU, alu_a=nd, alu_b=1; nd <= alu_out (two's complement of divisor). Go to DIV.
- DIV (restoring, 32 cycles, T+3..T+34). Registers: rem=0, quo=dividend.
  - Shifted remainder s={rem,quo[31]} (33 bits). Drive alu ADDU, alu_a=s[31:0], alu_b=nd.
  - ge = s[32] | alu_flags[0].
  - If ge: rem<=alu_out, else rem<=s[31:0]. quo<={quo[30:0], ge}.
  - When counter==31, go to DONE.
- DONE (one cycle):
  - done=1, busy=1, results visible.
  - MULU: res_hi=hi, res_lo=lo.
  - DIVU: res_lo=quo, res_hi=rem.
  - Divide by zero: res_lo=32'hFFFF_FFFF, res_hi=dividend, div_zero=1.
  - Next state IDLE.
- res_lo/res_hi/div_zero hold their values until the next accepted start, then track internal registers.
- Latency from the accepting cycle T: MULU done at T+33; DIVU done at T+35; DIVU by zero done at T+1.
- Width rules: all arithmetic is modulo 2^32 through the alu; the carry is taken only from alu_flags[0]. The block never reads alu_flags[1] or alu_flags[2].

Test Plan:
- MULU 3*5, start at cycle T -> busy from T+1; done pulse only at T+33; res_hi=0, res_lo=15.
- MULU 0xFFFFFFFF*0xFFFFFFFF -> res_hi=0xFFFFFFFE, res_lo=0x00000001; carry path exercised.
- DIVU 100/7 -> done at T+35, res_lo=14, res_hi=2, div_zero=0. Also DIVU 0xFFFFFFFF/1 -> res_lo=0xFFFFFFFF, res_hi=0.
- DIVU 0x12345678/0 -> done at T+1, res_lo=0xFFFFFFFF, res_hi=0x12345678, div_zero=1. A following MULU start clears div_zero.
- start pulsed at T+5 during a MULU with different operands -> ignored; original result returned at T+33.
- rst asserted at T+10 of a DIVU -> next cycle busy=0, done=0, res_lo=res_hi=0, state IDLE. A start two cycles later completes normally.
